// File: rtl/v_alu_pkg.sv
// Shared vector ALU definitions: SEW encoding, packed sub_result lane layout and
// element byte-position helpers used by the subtractor and the min/max selector.
package v_alu_pkg;

    typedef enum logic [1:0] {
        Sew8  = 2'd0,
        Sew16 = 2'd1,
        Sew32 = 2'd2,
        Sew64 = 2'd3
    } sew_e;

    localparam int unsigned LANE_W        = 10;
    localparam int unsigned LANE_DATA_LSB = 1;
    localparam int unsigned LANE_SIGN_BIT = 9;

    // Bytes per element; without 64-bit support sew=3 collapses to 32-bit elements.
    function automatic int unsigned elem_bytes(input logic [1:0] sew, input logic en64);
        if ((sew == Sew64) && !en64) begin
            return 32'd4;
        end
        return 32'd1 << sew;
    endfunction

    function automatic logic elem_lsb(input logic [1:0] sew, input int unsigned byte_idx,
                                      input logic en64);
        return (byte_idx & (elem_bytes(sew, en64) - 32'd1)) == 32'd0;
    endfunction

    function automatic logic elem_msb(input logic [1:0] sew, input int unsigned byte_idx,
                                      input logic en64);
        return (byte_idx & (elem_bytes(sew, en64) - 32'd1)) == (elem_bytes(sew, en64) - 32'd1);
    endfunction

endpackage

// File: rtl/v_seg_operand_fmt.sv
// Combinational guard-bit formatter: builds the A/B adder operands for one SEW so a single
// wide add yields per-element vec0 - vec1. Honours V_SEGSUB_64_EN for 64-bit elements.
module v_seg_operand_fmt
    import v_alu_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH      = 2
) (
    input  logic [REQ_DATA_WIDTH-1:0]                 vec0_i,
    input  logic [REQ_DATA_WIDTH-1:0]                 vec1_i,
    input  logic [SEW_WIDTH-1:0]                      sew_i,
    input  logic                                      signed_i,
    output logic [LANE_W*(REQ_DATA_WIDTH/8)-1:0]      a_o,
    output logic [LANE_W*(REQ_DATA_WIDTH/8)-1:0]      b_o
);

    localparam int unsigned BeW = REQ_DATA_WIDTH / 8;

`ifdef V_SEGSUB_64_EN
    localparam logic En64 = (REQ_DATA_WIDTH >= 64);
`else
    localparam logic En64 = 1'b0;
`endif

    logic [1:0] sew2;
    assign sew2 = sew_i[1:0];

    always_comb begin
        a_o = '0;
        b_o = '0;
        for (int unsigned k = 0; k < BeW; k++) begin
            // Default lane: both guards propagate the carry through untouched.
            a_o[LANE_W*k +: LANE_W] = {1'b1, vec0_i[8*k +: 8], 1'b1};
            b_o[LANE_W*k +: LANE_W] = {1'b0, ~vec1_i[8*k +: 8], 1'b0};
            // 1+1 at the element LSB injects the +1 and swallows the neighbour's carry.
            if (elem_lsb(sew2, k, En64)) begin
                b_o[LANE_W*k] = 1'b1;
            end
            if (elem_msb(sew2, k, En64)) begin
                a_o[LANE_W*k + LANE_SIGN_BIT] = signed_i & vec0_i[8*k + 7];
                b_o[LANE_W*k + LANE_SIGN_BIT] = ~(signed_i & vec1_i[8*k + 7]);
            end
        end
    end

endmodule

// File: rtl/v_seg_subtractor.sv
// Two-stage segmented subtractor: stage 1 registers formatted operands, stage 2 the wide sum.
// Optional 64-bit elements via V_SEGSUB_64_EN (see v_seg_operand_fmt).
module v_seg_subtractor
    import v_alu_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH      = 2,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REQ_DATA_WIDTH-1:0] in_vec0,
    input  logic [REQ_DATA_WIDTH-1:0] in_vec1,
    input  logic [SEW_WIDTH-1:0]      in_sew,
    input  logic                      in_signed,
    input  logic                      in_minmax_sel,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REQ_DATA_WIDTH-1:0] out_vec0,
    output logic [REQ_DATA_WIDTH-1:0] out_vec1,
    output logic [SEW_WIDTH-1:0]      out_sew,
    output logic                      out_minmax_sel,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [REQ_DATA_WIDTH+16:0] out_sub_result,
    output logic                      busy
);

    localparam int unsigned SumW = LANE_W * REQ_BE_WIDTH;
    localparam int unsigned PadW = REQ_DATA_WIDTH + 17 - SumW;

    logic [SumW-1:0] fmt_a, fmt_b;

    logic                      s1_valid_q, s1_valid_d;
    logic [SumW-1:0]           s1_a_q, s1_a_d;
    logic [SumW-1:0]           s1_b_q, s1_b_d;
    logic [REQ_DATA_WIDTH-1:0] s1_vec0_q, s1_vec0_d;
    logic [REQ_DATA_WIDTH-1:0] s1_vec1_q, s1_vec1_d;
    logic [SEW_WIDTH-1:0]      s1_sew_q, s1_sew_d;
    logic                      s1_sel_q, s1_sel_d;
    logic [TAG_WIDTH-1:0]      s1_tag_q, s1_tag_d;

    logic                      s2_valid_q, s2_valid_d;
    logic [SumW-1:0]           s2_sum_q, s2_sum_d;
    logic [REQ_DATA_WIDTH-1:0] s2_vec0_q, s2_vec0_d;
    logic [REQ_DATA_WIDTH-1:0] s2_vec1_q, s2_vec1_d;
    logic [SEW_WIDTH-1:0]      s2_sew_q, s2_sew_d;
    logic                      s2_sel_q, s2_sel_d;
    logic [TAG_WIDTH-1:0]      s2_tag_q, s2_tag_d;

    logic s1_adv;

    v_seg_operand_fmt #(
        .REQ_DATA_WIDTH (REQ_DATA_WIDTH),
        .SEW_WIDTH      (SEW_WIDTH)
    ) u_fmt (
        .vec0_i   (in_vec0),
        .vec1_i   (in_vec1),
        .sew_i    (in_sew),
        .signed_i (in_signed),
        .a_o      (fmt_a),
        .b_o      (fmt_b)
    );

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_vec0_d  = s1_vec0_q;
        s1_vec1_d  = s1_vec1_q;
        s1_sew_d   = s1_sew_q;
        s1_sel_d   = s1_sel_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_vec0_d  = s2_vec0_q;
        s2_vec1_d  = s2_vec1_q;
        s2_sew_d   = s2_sew_q;
        s2_sel_d   = s2_sel_q;
        s2_tag_d   = s2_tag_q;

        // Payload only moves on a real transfer so a stalled output stays stable.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d  = s1_a_q + s1_b_q;
                s2_vec0_d = s1_vec0_q;
                s2_vec1_d = s1_vec1_q;
                s2_sew_d  = s1_sew_q;
                s2_sel_d  = s1_sel_q;
                s2_tag_d  = s1_tag_q;
            end
        end

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = fmt_a;
                s1_b_d    = fmt_b;
                s1_vec0_d = in_vec0;
                s1_vec1_d = in_vec1;
                s1_sew_d  = in_sew;
                s1_sel_d  = in_minmax_sel;
                s1_tag_d  = in_tag;
            end
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_vec0_q  <= '0;
            s1_vec1_q  <= '0;
            s1_sew_q   <= '0;
            s1_sel_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_vec0_q  <= '0;
            s2_vec1_q  <= '0;
            s2_sew_q   <= '0;
            s2_sel_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_vec0_q  <= s1_vec0_d;
            s1_vec1_q  <= s1_vec1_d;
            s1_sew_q   <= s1_sew_d;
            s1_sel_q   <= s1_sel_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_vec0_q  <= s2_vec0_d;
            s2_vec1_q  <= s2_vec1_d;
            s2_sew_q   <= s2_sew_d;
            s2_sel_q   <= s2_sel_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_vec0       = s2_vec0_q;
    assign out_vec1       = s2_vec1_q;
    assign out_sew        = s2_sew_q;
    assign out_minmax_sel = s2_sel_q;
    assign out_tag        = s2_tag_q;
    assign out_sub_result = {{PadW{1'b0}}, s2_sum_q};
    assign busy           = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_v_seg_subtractor.sv
// Bench for v_seg_subtractor: directed corner cases plus randomized traffic checked
// against an arithmetic per-element difference / compare model.
module tb_v_seg_subtractor;

`ifdef V_SEGSUB_64_EN
    localparam bit En64 = 1'b1;
`else
    localparam bit En64 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [63:0] in_vec0, in_vec1;
    logic [1:0]  in_sew;
    logic        in_signed, in_minmax_sel;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready;
    logic [63:0] out_vec0, out_vec1;
    logic [1:0]  out_sew;
    logic        out_minmax_sel;
    logic [3:0]  out_tag;
    logic [80:0] out_sub_result;
    logic        busy;

    always #5 clk = ~clk;

    v_seg_subtractor dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_vec0        (in_vec0),
        .in_vec1        (in_vec1),
        .in_sew         (in_sew),
        .in_signed      (in_signed),
        .in_minmax_sel  (in_minmax_sel),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vec0       (out_vec0),
        .out_vec1       (out_vec1),
        .out_sew        (out_sew),
        .out_minmax_sel (out_minmax_sel),
        .out_tag        (out_tag),
        .out_sub_result (out_sub_result),
        .busy           (busy)
    );

    typedef struct {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [1:0]  sew;
        logic        sgn;
        logic        sel;
        logic [3:0]  tag;
    } op_t;

    op_t         q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic        hold_v = 1'b0;
    logic [3:0]  hold_tag;
    logic [80:0] hold_res;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected result from plain per-element arithmetic on the operands.
    task automatic check_op(input op_t op);
        logic [127:0] want, mask, got;
        logic [7:0]   eqv, eqg;
        logic [63:0]  m, ua, ub, sa, sb, d;
        logic         lt, z;
        int           eb, nel, n, k;
        eb   = (op.sew == 2'd3) ? (En64 ? 8 : 4) : (1 << op.sew);
        nel  = 8 / eb;
        n    = 8 * eb;
        m    = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        want = '0;
        mask = '0;
        eqv  = '0;
        eqg  = '0;
        got  = '0;
        got[80:0] = out_sub_result;
        for (int e = 0; e < nel; e++) begin
            ua = (op.v0 >> (n * e)) & m;
            ub = (op.v1 >> (n * e)) & m;
            d  = (ua - ub) & m;
            sa = ua[n-1] ? (ua | ~m) : ua;
            sb = ub[n-1] ? (ub | ~m) : ub;
            lt = op.sgn ? ($signed(sa) < $signed(sb)) : (ua < ub);
            eqv[e] = (ua == ub);
            z = 1'b1;
            for (int j = 0; j < eb; j++) begin
                k = e * eb + j;
                want[10*k+1 +: 8] = d[8*j +: 8];
                mask[10*k+1 +: 8] = 8'hFF;
                if (j == eb - 1) begin
                    want[10*k+9] = lt;
                    mask[10*k+9] = 1'b1;
                end
                if (|got[10*k+1 +: 9]) z = 1'b0;
            end
            eqg[e] = z;
        end
        mask[127:80] = '1;
        check_eq("result", got & mask, want);
        check_eq("equal", {120'd0, eqg}, {120'd0, eqv});
        check_eq("vec0", {64'd0, out_vec0}, {64'd0, op.v0});
        check_eq("vec1", {64'd0, out_vec1}, {64'd0, op.v1});
        check_eq("fields", {121'd0, out_sew, out_minmax_sel, out_tag},
                 {121'd0, op.sew, op.sel, op.tag});
    endtask

    always @(negedge clk) begin
        op_t op;
        if (rst || flush) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_eq("hold", {42'd0, out_valid, out_tag, out_sub_result},
                         {42'd0, 1'b1, hold_tag, hold_res});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check_eq("spurious_out", 128'd1, 128'd0);
                end else begin
                    op = q.pop_front();
                    check_op(op);
                end
            end
            if (in_valid && in_ready) begin
                op.v0 = in_vec0; op.v1 = in_vec1; op.sew = in_sew;
                op.sgn = in_signed; op.sel = in_minmax_sel; op.tag = in_tag;
                q.push_back(op);
            end
            hold_v   = out_valid && !out_ready;
            hold_tag = out_tag;
            hold_res = out_sub_result;
        end
    end

    task automatic push_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                           input logic sg, input logic [3:0] tg);
        logic acc;
        in_vec0 = a; in_vec1 = b; in_sew = s; in_signed = sg;
        in_minmax_sel = tg[0]; in_tag = tg; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check_eq("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic send_and_get(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                                input logic sg, output logic [80:0] res);
        int lat;
        out_ready = 1'b1;
        push_op(a, b, s, sg, 4'hA);
        lat = -1;
        res = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                res = out_sub_result;
                break;
            end
        end
        check_eq("latency", lat, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [80:0] res;
        logic [2:0]  acc_bits;
        logic        acc;
        logic [3:0]  t;
        int          base, r;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_vec0 = '0; in_vec1 = '0; in_sew = '0; in_signed = 1'b0;
        in_minmax_sel = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_result", out_sub_result, 0);
        check_eq("rst_fwd", {out_vec0, out_tag}, 0);
        @(posedge clk);
        #1;

        send_and_get(64'h7F, 64'h80, 2'd0, 1'b1, res);
        check_eq("s8_signed_lt", res[9], 0);
        send_and_get(64'h7F, 64'h80, 2'd0, 1'b0, res);
        check_eq("s8_unsigned_lt", res[9], 1);
        send_and_get(64'h0001, 64'h0100, 2'd1, 1'b0, res);
        check_eq("s16_lt", res[19], 1);
        send_and_get(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'd3, 1'b0, res);
        for (int k = 0; k < 8; k++) check_eq("s64_equal", res[10*k+1 +: 9], 0);
`ifndef V_SEGSUB_64_EN
        send_and_get(64'h00000001_00000000, 64'h1, 2'd3, 1'b0, res);
        check_eq("sew3_as32_e0", res[39], 1);
        check_eq("sew3_as32_e1", res[79], 0);
`endif

        // Back-to-back tags under a stalled consumer.
        base = n_out;
        out_ready = 1'b0;
        in_valid = 1'b1;
        t = 4'd1;
        acc_bits = '0;
        for (int c = 0; c < 3; c++) begin
            in_tag = t; in_vec0 = {$urandom, $urandom}; in_vec1 = {$urandom, $urandom};
            @(negedge clk);
            acc_bits[c] = in_ready;
            @(posedge clk);
            #1;
            if (acc_bits[c]) t = t + 4'd1;
        end
        check_eq("inready_drop", acc_bits, 3'b011);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_tag = t;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        check_eq("tag3_accept", acc, 1);
        repeat (6) @(posedge clk);
        #1;
        check_eq("tag_count", n_out - base, 3);

        // Flush with two ops in flight; the op presented alongside flush is dropped.
        out_ready = 1'b0;
        push_op(64'h11, 64'h22, 2'd0, 1'b0, 4'd5);
        push_op(64'h33, 64'h44, 2'd1, 1'b1, 4'd6);
        check_eq("busy_full", busy, 1);
        base = n_out;
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'd7;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_busy", busy, 0);
        check_eq("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("flush_no_out", n_out - base, 0);

        // Reset mid-stream.
        out_ready = 1'b0;
        push_op(64'hFFFF, 64'h1, 2'd2, 1'b1, 4'd8);
        push_op(64'h1234, 64'h1234, 2'd3, 1'b0, 4'd9);
        base = n_out;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst2_out_valid", out_valid, 0);
        check_eq("rst2_busy", busy, 0);
        check_eq("rst2_in_ready", in_ready, 1);
        check_eq("rst2_result", out_sub_result, 0);
        check_eq("rst2_fwd", {out_vec0, out_vec1, out_sew, out_minmax_sel, out_tag}, 0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst2_no_out", n_out - base, 0);

        // Randomized traffic with stalls and occasional flushes.
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_vec0 = {$urandom, $urandom};
            in_vec1 = {$urandom, $urandom};
            r = $urandom_range(0, 3);
            if (r == 0) in_vec1 = in_vec0;
            else if (r == 1) in_vec1 = in_vec0 ^ (64'hFF << (8 * $urandom_range(0, 7)));
            in_sew = 2'($urandom_range(0, 3));
            in_signed = 1'($urandom_range(0, 1));
            in_minmax_sel = 1'($urandom_range(0, 1));
            in_tag = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("drain", q.size(), 0);
        check_eq("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/v_seg_subtractor.md
# v_seg_subtractor

Pipelined segmented subtractor feeding the vector ALU min/max/compare selector. Computes per-element vec0 − vec1 for SEW 8/16/32/64 in one wide carry chain with 2 guard bits per byte, producing the packed sub_result format (10 bits per byte) that the selector decodes into lt/equal/min/max. Two register stages with valid/ready backpressure. Operands, sew and select are forwarded aligned with the result.

## Interface
- REQ_DATA_WIDTH, 64, operand width in bits (32 or 64)
- SEW_WIDTH, 2, sew field width
- TAG_WIDTH, 4, opaque tag carried with each op
- REQ_BE_WIDTH, REQ_DATA_WIDTH/8, bytes per operand

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous drop of all in-flight ops
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_vec0 / in_vec1  in  REQ_DATA_WIDTH  minuend / subtrahend
- in_sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=64b
- in_signed  in  1  signed compare when 1
- in_minmax_sel  in  1  forwarded unchanged
- in_tag  in  TAG_WIDTH  forwarded unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_vec0 / out_vec1  out  REQ_DATA_WIDTH  forwarded operands
- out_sew, out_minmax_sel, out_tag  out  as inputs  forwarded fields
- out_sub_result  out  REQ_DATA_WIDTH+17  packed difference
- busy  out  1  either stage valid

## Operation
- Byte k occupies lane bits [10k +: 10]: bit 0 = carry guard, bits 1..8 = byte data, bit 9 = upper guard. Bits above 10·REQ_BE_WIDTH driven 0.
- Adder computes A + B (plain add, no external carry-in); A/B built per byte:
  - data bits: A = vec0 byte, B = ~vec1 byte.
  - bit 0, element-LSB byte: A=1, B=1 (injects +1, kills carry from previous element); other bytes: A=1, B=0 (propagate).
  - bit 9, element-MSB byte: A = in_signed & vec0 element MSB, B = ~(in_signed & vec1 element MSB); other bytes: A=1, B=0.
- Result: element-MSB bit 9 = 1 iff vec0 < vec1; bits [10k+1 +: 9] all zero for every byte of an element iff equal.
- Stage 1 registers formatted A/B plus forwarded fields; stage 2 registers the sum.
- Handshake: s1_adv = !s2_valid || out_ready; in_ready = !s1_valid || s1_adv (combinational from out_ready, allowed). Payload held stable while out_valid && !out_ready.
- flush: both valids cleared at the edge; an input presented in the same cycle is dropped; in_ready=1 next cycle.

## Timing
- Latency 2: op accepted at edge N has out_valid=1 after edge N+1 absent stall. Throughput 1/cycle.
- Reset: out_valid=0, busy=0, in_ready=1 after reset; all out_* data registers reset to 0.
- rst mid-operation: in-flight ops discarded, no output produced.
- Simultaneous out handshake and new input with full pipe: both stages advance, no bubble.

## Configuration
- V_SEGSUB_64_EN defined: sew=3 is a 64-bit element (byte 0 LSB, byte 7 MSB).
- Undefined: sew=3 treated exactly as sew=2 (32-bit elements); out_sew still forwards 3. REQ_DATA_WIDTH<64 behaves as undefined regardless.

## Structure
- Shared package v_alu_pkg: sew encoding enum, LANE_W=10, LANE_DATA_LSB=1, LANE_SIGN_BIT=9, elem_msb/elem_lsb byte-position functions (also used by the selector).
- One sub-module v_seg_operand_fmt: combinational A/B guard-bit formatter for one sew; instantiated once, output registered in stage 1.

## Test plan
- sew=0, byte0 vec0=0x7F vec1=0x80, in_signed=1 -> out_sub_result[9]=0; in_signed=0 -> [9]=1.
- sew=3 (macro on), vec0=vec1=0x0123456789ABCDEF -> bits [10k+1 +: 9]=0 for k=0..7.
- sew=1 unsigned, vec0=0x0001, vec1=0x0100 in element 0 -> bit 19=1.
- Macro off, sew=3, vec0=0x00000001_00000000, vec1=0x1 unsigned -> bit 39=1, bit 79=0.
- Tags 1,2,3 back-to-back, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; outputs tags 1,2,3 in order, none lost/duplicated.
- flush with 2 ops in flight -> out_valid=0 next cycle, busy=0, in_ready=1; rst mid-stream -> same plus all outputs 0.
